// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded instruction fields, packs them into 32-bit
// MIPS-style words and streams them to instruction memory at consecutive addresses.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [7:0]  count,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  localparam logic [7:0] MAXW = 8'(MAX_WORDS);

  state_t     state, state_nxt;
  logic       last_q;
  logic       legal;
  logic [7:0] count_inc;

  function automatic logic [31:0] encode(input logic [3:0]  kind,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [15:0] imm,
                                         input logic [25:0] target);
    logic [31:0] w;
    case (kind)
      4'd0:    w = {6'b100011, rs, rt, imm};
      4'd1:    w = {6'b101011, rs, rt, imm};
      4'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b011100};
      4'd6:    w = {6'b001000, rs, rt, imm};
      4'd7:    w = {6'b000100, rs, rt, imm};
      4'd8:    w = {6'b000010, target};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign legal     = (in_kind <= 4'd8);
  assign count_inc = count + 8'd1;

  // Outputs decode straight from state so an async reset drops imem_we at once
  assign in_ready = (state == ACCEPT);
  assign imem_we  = (state == WRITE);
  assign busy     = (state == ACCEPT) || (state == WRITE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = ACCEPT;
      ACCEPT:     if (in_valid && legal) state_nxt = WRITE;
      WRITE:      state_nxt = (last_q || count_inc == MAXW) ? DONE : ACCEPT;
      default:    state_nxt = IDLE;
    endcase
  end

  // Word capture at transfer; address/count advance as WRITE is left
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'h0000_0000;
      count      <= 8'd0;
      err        <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            imem_addr <= BASE_ADDR;
            count     <= 8'd0;
            err       <= 1'b0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            if (legal) begin
              imem_wdata <= encode(in_kind, in_rs, in_rt, in_rd, in_imm, in_target);
              last_q     <= in_last;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          imem_addr <= imem_addr + 32'd4;
          count     <= count_inc;
          if (!last_q && count_inc == MAXW) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized sessions checked
// against an arithmetic encoding model and a word-index address/count model.
module tb_instr_encoder;

  localparam logic [31:0] BASE2 = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic        in_valid, in_valid2;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  logic        in_ready, imem_we, busy, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [7:0]  count;

  logic        in_ready2, imem_we2, busy2, done2, err2;
  logic [31:0] imem_addr2, imem_wdata2;
  logic [7:0]  count2;

  int n_checks = 0;
  int n_fail   = 0;
  int idx      = 0;
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .busy(busy), .done(done), .err(err)
  );

  instr_encoder #(.BASE_ADDR(BASE2), .MAX_WORDS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we2), .imem_addr(imem_addr2),
    .imem_wdata(imem_wdata2), .count(count2), .busy(busy2), .done(done2), .err(err2)
  );

  // Reference encoding built from opcode/funct numbers with shifts-by-multiplication
  function automatic logic [31:0] ref_encode(input int k, input int rs, input int rt,
                                             input int rd, input int imm, input int tgt);
    int unsigned op, fn;
    op = 0; fn = 0;
    case (k)
      0: op = 35;
      1: op = 43;
      6: op = 8;
      7: op = 4;
      2: fn = 32;
      3: fn = 34;
      4: fn = 42;
      5: fn = 28;
      default: ;
    endcase
    if (k == 8)
      return 32'(2 * 67108864 + tgt);
    else if (k >= 2 && k <= 5)
      return 32'(rs * 2097152 + rt * 65536 + rd * 2048 + fn);
    else
      return 32'(op * 67108864 + rs * 2097152 + rt * 65536 + imm);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    idx = 0;
    exp_err = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", in_ready, 1);
    chk("start_count", count, 0);
    chk("start_err", err, 0);
    chk("start_addr", imem_addr, 0);
  endtask

  task automatic send(input int k, input int rs, input int rt, input int rd,
                      input int imm, input int tgt, input logic last);
    logic [31:0] prev_wdata;
    prev_wdata = imem_wdata;
    chk("pre_ready", in_ready, 1);
    in_kind = 4'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    if (k > 8) begin
      exp_err = 1'b1;
      chk("ill_we", imem_we, 0);
      chk("ill_ready", in_ready, 1);
      chk("ill_err", err, 1);
      chk("ill_addr", imem_addr, 32'(4 * idx));
      chk("ill_count", count, idx);
      chk("ill_wdata", imem_wdata, prev_wdata);
    end else begin
      chk("wr_we", imem_we, 1);
      chk("wr_ready", in_ready, 0);
      chk("wr_addr", imem_addr, 32'(4 * idx));
      chk("wr_wdata", imem_wdata, ref_encode(k, rs, rt, rd, imm, tgt));
      tick();
      idx++;
      chk("post_we", imem_we, 0);
      chk("post_count", count, idx);
      chk("post_addr", imem_addr, 32'(4 * idx));
      chk("post_wdata", imem_wdata, ref_encode(k, rs, rt, rd, imm, tgt));
      if (!last && idx == 64) exp_err = 1'b1;
      chk("post_done", done, (last || idx == 64) ? 1 : 0);
      chk("post_err", err, exp_err);
    end
  endtask

  initial begin
    int n, sent, k;
    logic lst;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    in_last = 1'b0;
    #2;
    chk("rst_we", imem_we, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_addr2", imem_addr2, BASE2);
    #10 reset = 1'b0;
    tick();
    chk("idle_ready", in_ready, 0);
    start = 1'b0;

    // Directed session: add, lw, j(last)
    do_start();
    send(2, 1, 2, 3, 16'hBEEF, 0, 1'b0);
    chk("d1_wdata", imem_wdata, 32'h0022_1820);
    send(0, 29, 8, 31, 16'h0004, 26'h3FF_FFFF, 1'b0);
    chk("d2_wdata", imem_wdata, 32'h8FA8_0004);
    send(8, 7, 7, 7, 16'h1234, 26'h000_0010, 1'b1);
    chk("d3_wdata", imem_wdata, 32'h0800_0010);
    chk("d3_busy", busy, 0);
    chk("d3_ready", in_ready, 0);
    tick();
    chk("done_hold", done, 1);
    chk("done_addr_hold", imem_addr, 32'h0000_000C);

    // Illegal kind, start ignored mid-session, err sticky until next start
    do_start();
    send(6, 4, 5, 0, 16'hFFFF, 0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_start_count", count, 1);
    chk("ign_start_addr", imem_addr, 32'h4);
    send(15, 0, 0, 0, 0, 0, 1'b0);
    send(3, 9, 10, 11, 0, 0, 1'b0);
    send(7, 1, 1, 0, 16'hFFFE, 0, 1'b1);
    chk("sticky_err", err, 1);
    do_start();

    // Reset during WRITE drops the strobe without a clock edge
    in_kind = 4'd4; in_rs = 5'd3; in_rt = 5'd4; in_rd = 5'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rw_we_before", imem_we, 1);
    reset = 1'b1;
    #1;
    chk("rw_we_async", imem_we, 0);
    chk("rw_busy", busy, 0);
    chk("rw_addr", imem_addr, 0);
    chk("rw_count", count, 0);
    #1 reset = 1'b0;
    tick();
    chk("rw_idle_ready", in_ready, 0);
    do_start();
    send(1, 2, 3, 0, 16'h8000, 0, 1'b1);

    // Truncation at MAX_WORDS=2 on the second instance
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      in_kind = 4'd2; in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
      in_last = 1'b0; in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      chk("t_we", imem_we2, 1);
      chk("t_addr", imem_addr2, BASE2 + 32'(4 * w));
      chk("t_wdata", imem_wdata2, ref_encode(2, int'(in_rs), int'(in_rt), int'(in_rd), 0, 0));
      tick();
      chk("t_count", count2, w + 1);
    end
    chk("t_done", done2, 1);
    chk("t_err", err2, 1);
    in_valid2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t_third_ready", in_ready2, 0);
      chk("t_third_we", imem_we2, 0);
      chk("t_third_count", count2, 2);
    end
    in_valid2 = 1'b0;

    // Randomized sessions, kinds 9..11 exercise the illegal path
    for (int s = 0; s < 30; s++) begin
      do_start();
      n = $urandom_range(1, 5);
      sent = 0;
      while (sent < n) begin
        k = $urandom_range(0, 11);
        lst = (k <= 8) && (sent == n - 1);
        send(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 65535), int'($urandom & 32'h03FF_FFFF), lst);
        if (k <= 8) sent++;
      end
      chk("rs_done", done, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
